// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and default width.
package seq_restoring_divider_pkg;

    localparam int DEF_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring division iteration: shift {P,W} left, trial-subtract D through a
// ripple chain of full adders, and restore P when the subtraction borrows.
module seq_restoring_divider_ha (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module seq_restoring_divider_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    logic w_s1;
    logic w_c1;
    logic w_c2;

    seq_restoring_divider_ha u_ha0 (.i_a(i_a),  .i_b(i_b),   .o_s(w_s1), .o_c(w_c1));
    seq_restoring_divider_ha u_ha1 (.i_a(w_s1), .i_b(i_cin), .o_s(o_s),  .o_c(w_c2));

    assign o_cout = w_c1 | w_c2;
endmodule

module seq_restoring_divider_div_step #(
    parameter int N = 4
) (
    input  logic [N:0]   i_p,
    input  logic [N-1:0] i_w,
    input  logic [N-1:0] i_d,
    output logic [N:0]   o_p_next,
    output logic [N-1:0] o_w_next
);
    logic [N:0]   w_tp;
    logic [N:0]   w_sub;
    logic [N:0]   w_diff;
    logic [N+1:0] w_carry;
    logic         w_no_borrow;

    assign w_tp       = {i_p[N-1:0], i_w[N-1]};
    assign w_sub      = ~{1'b0, i_d};
    assign w_carry[0] = 1'b1;

    for (genvar i = 0; i <= N; i++) begin : g_bit
        seq_restoring_divider_fa u_fa (
            .i_a   (w_tp[i]),
            .i_b   (w_sub[i]),
            .i_cin (w_carry[i]),
            .o_s   (w_diff[i]),
            .o_cout(w_carry[i+1])
        );
    end

    // Carry out means T.P >= D; a set bit shifted out of P would also guarantee it.
    assign w_no_borrow = w_carry[N+1] | i_p[N];
    assign o_p_next    = w_no_borrow ? w_diff : w_tp;
    assign o_w_next    = {i_w[N-2:0], w_no_borrow};
endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned radix-2 restoring divider, one quotient bit per clock,
// with a start/busy/done handshake.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         dbz
);
    localparam int CW = $clog2(N + 1);

    div_state_t   r_state;
    div_state_t   w_next_state;
    logic [N:0]   r_p;
    logic [N-1:0] r_w;
    logic [N-1:0] r_d;
    logic [CW-1:0] r_cnt;
    logic [N-1:0] r_q;
    logic [N-1:0] r_r;
    logic         r_dbz;
    logic         r_dbz_wait;
    logic [N:0]   w_p_next;
    logic [N-1:0] w_w_next;
    logic         w_last;

    seq_restoring_divider_div_step #(.N(N)) u_step (
        .i_p     (r_p),
        .i_w     (r_w),
        .i_d     (r_d),
        .o_p_next(w_p_next),
        .o_w_next(w_w_next)
    );

    assign w_last = (r_cnt == CW'(N - 1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (B != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            // A divide-by-zero result spends one extra cycle here so done lands
            // one edge after the start edge, like a one-iteration operation.
            ST_DONE: begin
                if (!r_dbz_wait) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_p        <= '0;
            r_w        <= '0;
            r_d        <= '0;
            r_cnt      <= '0;
            r_q        <= '0;
            r_r        <= '0;
            r_dbz      <= 1'b0;
            r_dbz_wait <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (B != '0) begin
                            r_p   <= '0;
                            r_w   <= A;
                            r_d   <= B;
                            r_cnt <= '0;
                        end else begin
                            r_q        <= '1;
                            r_r        <= A;
                            r_dbz      <= 1'b1;
                            r_dbz_wait <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_p   <= w_p_next;
                    r_w   <= w_w_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_q   <= w_w_next;
                        r_r   <= w_p_next[N-1:0];
                        r_dbz <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_dbz_wait <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign Q    = r_q;
    assign R    = r_r;
    assign dbz  = r_dbz;
    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE) && !r_dbz_wait;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (N=4) against a plain a/b, a%b model.
module tb_seq_restoring_divider;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic [N-1:0] Q;
    logic [N-1:0] R;
    logic         busy;
    logic         done;
    logic         dbz;

    int checks = 0;
    int failures = 0;

    seq_restoring_divider #(.N(N)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .A    (A),
        .B    (B),
        .Q    (Q),
        .R    (R),
        .busy (busy),
        .done (done),
        .dbz  (dbz)
    );

    always #5 clk = ~clk;

    // Drives one start (called at a negedge with the divider idle), scrambles A/B
    // right after the start edge, then waits for done. Latency is counted in
    // negedges after the start edge; -1 means done never arrived.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          output int lat, output int nbusy,
                          output bit held, output bit single);
        logic [N-1:0] q0;
        logic [N-1:0] r0;
        logic         z0;
        q0 = Q; r0 = R; z0 = dbz;
        start = 1'b1; A = a; B = b;
        @(negedge clk);
        start = 1'b0; A = N'($urandom); B = N'($urandom);
        lat = -1; nbusy = 0; held = 1'b1; single = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            if (busy === 1'b1) nbusy++;
            if (Q !== q0 || R !== r0 || dbz !== z0) held = 1'b0;
            @(negedge clk);
        end
        if (lat > 0) begin
            @(negedge clk);
            single = (done === 1'b0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({Q, R} !== '0) begin
            failures++;
            $display("FAIL reset_qr got Q=%0d R=%0d exp Q=0 R=0", Q, R);
        end
        checks++;
        if ({busy, done, dbz} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got busy=%b done=%b dbz=%b exp 000", busy, done, dbz);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, nb; bit held, single;
        run_op(4'd13, 4'd3, lat, nb, held, single);
        checks++;
        if (lat != N + 1 || nb != N) begin
            failures++;
            $display("FAIL basic_timing got lat=%0d busy_cycles=%0d exp lat=%0d busy_cycles=%0d", lat, nb, N + 1, N);
        end
        checks++;
        if (Q !== 4'd4 || R !== 4'd1 || dbz !== 1'b0) begin
            failures++;
            $display("FAIL basic_result got Q=%0d R=%0d dbz=%b exp Q=4 R=1 dbz=0", Q, R, dbz);
        end
        checks++;
        if (!single) begin
            failures++;
            $display("FAIL basic_done_pulse got done still high exp one-cycle pulse");
        end
    endtask

    task automatic test_hold();
        int lat, nb; bit held, single;
        run_op(4'd15, 4'd1, lat, nb, held, single);
        checks++;
        if (Q !== 4'd15 || R !== 4'd0 || lat != N + 1) begin
            failures++;
            $display("FAIL div_by_one got Q=%0d R=%0d lat=%0d exp Q=15 R=0 lat=%0d", Q, R, lat, N + 1);
        end
        run_op(4'd3, 4'd5, lat, nb, held, single);
        checks++;
        if (!held) begin
            failures++;
            $display("FAIL hold_during_run got result changed before done exp held");
        end
        checks++;
        if (Q !== 4'd0 || R !== 4'd3) begin
            failures++;
            $display("FAIL a_lt_b got Q=%0d R=%0d exp Q=0 R=3", Q, R);
        end
    endtask

    task automatic test_dbz();
        int lat, nb; bit held, single;
        run_op(4'd7, 4'd0, lat, nb, held, single);
        checks++;
        if (lat != 2 || nb != 0 || !single) begin
            failures++;
            $display("FAIL dbz_timing got lat=%0d busy_cycles=%0d single=%0d exp lat=2 busy_cycles=0 single=1", lat, nb, single);
        end
        checks++;
        if (Q !== 4'd15 || R !== 4'd7 || dbz !== 1'b1) begin
            failures++;
            $display("FAIL dbz_result got Q=%0d R=%0d dbz=%b exp Q=15 R=7 dbz=1", Q, R, dbz);
        end
        run_op(4'd9, 4'd2, lat, nb, held, single);
        checks++;
        if (Q !== 4'd4 || R !== 4'd1 || dbz !== 1'b0) begin
            failures++;
            $display("FAIL after_dbz got Q=%0d R=%0d dbz=%b exp Q=4 R=1 dbz=0", Q, R, dbz);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        int extra;
        start = 1'b1; A = 4'd14; B = 4'd3;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            if (c == 2) begin
                start = 1'b1; A = 4'd6; B = 4'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (lat != N + 1 || Q !== 4'd4 || R !== 4'd2) begin
            failures++;
            $display("FAIL ignore_start got lat=%0d Q=%0d R=%0d exp lat=%0d Q=4 R=2", lat, Q, R, N + 1);
        end
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL ignore_no_second_op got active_cycles=%0d exp 0", extra);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, nb, seen; bit held, single;
        start = 1'b1; A = 4'd13; B = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({Q, R} !== '0 || busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_run got Q=%0d R=%0d busy=%b done=%b dbz=%b exp all 0", Q, R, busy, done, dbz);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_no_done got done_pulses=%0d exp 0", seen);
        end
        run_op(4'd10, 4'd3, lat, nb, held, single);
        checks++;
        if (Q !== 4'd3 || R !== 4'd1 || lat != N + 1) begin
            failures++;
            $display("FAIL after_reset got Q=%0d R=%0d lat=%0d exp Q=3 R=1 lat=%0d", Q, R, lat, N + 1);
        end
    endtask

    task automatic test_random();
        int lat, nb; bit held, single;
        int a, b, eq, er, ez, el;
        for (int i = 0; i < 24; i++) begin
            a = int'($urandom_range(15, 0));
            b = (i % 6 == 0) ? 0 : int'($urandom_range(15, 0));
            eq = (b == 0) ? 15 : a / b;
            er = (b == 0) ? a : a % b;
            ez = (b == 0) ? 1 : 0;
            el = (b == 0) ? 2 : N + 1;
            run_op(N'(a), N'(b), lat, nb, held, single);
            checks++;
            if (int'(Q) != eq || int'(R) != er || int'(dbz) != ez || lat != el || !single) begin
                failures++;
                $display("FAIL random_%0d A=%0d B=%0d got Q=%0d R=%0d dbz=%b lat=%0d exp Q=%0d R=%0d dbz=%0d lat=%0d",
                         i, a, b, Q, R, dbz, lat, eq, er, ez, el);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, nb; bit held, single;
        int qi, ri;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(N'(a), N'(b), lat, nb, held, single);
                qi = int'(Q);
                ri = int'(R);
                checks++;
                if (lat != ((b == 0) ? 2 : N + 1) || !single) begin
                    failures++;
                    $display("FAIL exh_done A=%0d B=%0d got lat=%0d single=%0d", a, b, lat, single);
                end
                checks++;
                if (b != 0) begin
                    if (qi * b + ri != a || ri >= b || dbz !== 1'b0) begin
                        failures++;
                        $display("FAIL exh_invariant A=%0d B=%0d got Q=%0d R=%0d dbz=%b exp Q*B+R=A R<B dbz=0",
                                 a, b, qi, ri, dbz);
                    end
                end else begin
                    if (qi != 15 || ri != a || dbz !== 1'b1) begin
                        failures++;
                        $display("FAIL exh_dbz A=%0d got Q=%0d R=%0d dbz=%b exp Q=15 R=%0d dbz=1", a, qi, ri, dbz, a);
                    end
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_hold();
        test_dbz();
        test_ignore_start();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
